// File: rtl/uart_ctrl.sv
// Byte UART: 8N1 transmitter and receiver with memory-mapped status flags.
// Receiver input is double-flopped; all outputs come straight from registers.
module uart_ctrl #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       rx_read,
    input  logic       con_read,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic [4:0] uart_con
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- transmitter ----------------
    state_t        tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_sh, tx_sh_n;
    logic          tx_line_n, tx_busy, tx_busy_n, tx_done, tx_done_set;

    always_comb begin
        tx_state_n  = tx_state;
        tx_cnt_n    = tx_cnt;
        tx_idx_n    = tx_idx;
        tx_sh_n     = tx_sh;
        tx_line_n   = uart_tx;
        tx_busy_n   = tx_busy;
        tx_done_set = 1'b0;
        case (tx_state)
            S_IDLE: if (tx_start) begin
                tx_state_n = S_START;
                tx_cnt_n   = '0;
                tx_idx_n   = '0;
                tx_sh_n    = tx_data;
                tx_line_n  = 1'b0;
                tx_busy_n  = 1'b1;
            end
            S_START: if (tx_cnt == LAST) begin
                tx_state_n = S_DATA;
                tx_cnt_n   = '0;
                tx_line_n  = tx_sh[0];
            end else tx_cnt_n = tx_cnt + 1'b1;
            S_DATA: if (tx_cnt == LAST) begin
                tx_cnt_n = '0;
                if (tx_idx == 3'd7) begin
                    tx_state_n = S_STOP;
                    tx_line_n  = 1'b1;
                end else begin
                    // shift register keeps the next bit in position 0
                    tx_idx_n  = tx_idx + 3'd1;
                    tx_sh_n   = {1'b0, tx_sh[7:1]};
                    tx_line_n = tx_sh[1];
                end
            end else tx_cnt_n = tx_cnt + 1'b1;
            S_STOP: if (tx_cnt == LAST) begin
                tx_state_n  = S_IDLE;
                tx_cnt_n    = '0;
                tx_busy_n   = 1'b0;
                tx_done_set = 1'b1;
            end else tx_cnt_n = tx_cnt + 1'b1;
            default: tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_sh    <= tx_sh_n;
            uart_tx  <= tx_line_n;
            tx_busy  <= tx_busy_n;
            if (tx_done_set)   tx_done <= 1'b1;
            else if (con_read) tx_done <= 1'b0;
        end
    end

    // ---------------- receiver ----------------
    logic          rx_s1, rx_s2, rx_prev;
    state_t        rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_sh, rx_sh_n;
    logic          rx_brk, rx_brk_n, rx_done, ferr_set;
    logic          rx_valid, rx_overrun, frame_error;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_sh_n    = rx_sh;
        rx_brk_n   = rx_brk;
        rx_done    = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            S_IDLE: if (rx_prev && !rx_s2) begin
                rx_state_n = S_START;
                rx_cnt_n   = '0;
            end
            S_START: if (rx_cnt == HALF) begin
                // restarting here puts every later sample mid-bit
                rx_cnt_n   = '0;
                rx_idx_n   = '0;
                rx_state_n = rx_s2 ? S_IDLE : S_DATA;
            end else rx_cnt_n = rx_cnt + 1'b1;
            S_DATA: if (rx_cnt == LAST) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_s2, rx_sh[7:1]};
                if (rx_idx == 3'd7) rx_state_n = S_STOP;
                else                rx_idx_n   = rx_idx + 3'd1;
            end else rx_cnt_n = rx_cnt + 1'b1;
            S_STOP: if (rx_brk) begin
                // bad stop bit: hold off until the line is idle again
                if (rx_s2) begin
                    rx_brk_n   = 1'b0;
                    rx_state_n = S_IDLE;
                end
            end else if (rx_cnt == LAST) begin
                rx_cnt_n = '0;
                if (rx_s2) begin
                    rx_done    = 1'b1;
                    rx_state_n = S_IDLE;
                end else begin
                    ferr_set = 1'b1;
                    rx_brk_n = 1'b1;
                end
            end else rx_cnt_n = rx_cnt + 1'b1;
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_prev     <= 1'b1;
            rx_state    <= S_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_sh       <= '0;
            rx_brk      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_sh    <= rx_sh_n;
            rx_brk   <= rx_brk_n;
            if (rx_done) rx_data <= rx_sh;
            if (rx_done)      rx_valid <= 1'b1;
            else if (rx_read) rx_valid <= 1'b0;
            if (rx_done && rx_valid && !rx_read) rx_overrun <= 1'b1;
            else if (con_read)                   rx_overrun <= 1'b0;
            if (ferr_set)      frame_error <= 1'b1;
            else if (con_read) frame_error <= 1'b0;
        end
    end

    assign uart_con = {frame_error, rx_overrun, tx_done, tx_busy, rx_valid};
endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate; DIV = CLK_FREQ/BAUD, integer-truncated, clock cycles per bit.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port tx_data  input  8  byte to transmit; drives from memory-map write data for 0x40000018.
REQ-006 SHALL have port tx_start  input  1  one-cycle strobe, CPU write to 0x40000018.
REQ-007 SHALL have port rx_read  input  1  one-cycle strobe, CPU read of 0x4000001C.
REQ-008 SHALL have port con_read  input  1  one-cycle strobe, CPU read of 0x40000020.
REQ-009 SHALL have port uart_rx  input  1  asynchronous serial input, idle high.
REQ-010 SHALL have port uart_tx  output  1  serial output, idle high.
REQ-011 SHALL have port rx_data  output  8  last received byte, feeds UART_RXD.
REQ-012 SHALL have port uart_con  output  5  status, feeds UART_CON: [0] rx_valid, [1] tx_busy, [2] tx_done, [3] rx_overrun, [4] frame_error.

Function
REQ-013 SHALL synchronise uart_rx through two flops before any use; receiver logic sees only the synchronised value.
REQ-014 TX FSM SHALL have states IDLE, START, DATA, STOP; per-bit counter counts 0..DIV-1, bit index 0..7.
REQ-015 tx_start in IDLE SHALL latch tx_data and enter START; uart_tx goes low and tx_busy goes 1 on the next rising edge.
REQ-016 TX SHALL hold start bit (0) DIV cycles, then 8 data bits LSB first DIV cycles each, then stop bit (1) DIV cycles, then return to IDLE.
REQ-017 On STOP->IDLE, tx_busy SHALL clear and tx_done SHALL set on the same edge.
REQ-018 tx_start while tx_busy=1 SHALL be ignored; the latched byte and the frame in flight are unaffected.
REQ-019 RX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-020 IDLE->START SHALL occur on synchronised 1->0 transition; START samples at count DIV/2; low -> DATA with counter restarted, high -> IDLE (glitch rejection).
REQ-021 DATA SHALL sample every DIV cycles, bit 0 first, into a shift register; after bit 7 -> STOP.
REQ-022 STOP SHALL sample after DIV cycles; sample 1: rx_data loads the byte, rx_valid sets, return to IDLE.
REQ-023 STOP sample 0: frame_error SHALL set, rx_data and rx_valid unchanged, FSM waits for line high before IDLE.
REQ-024 Byte completion while rx_valid=1 and no rx_read that cycle SHALL set rx_overrun and overwrite rx_data with the new byte.
REQ-025 rx_read SHALL clear rx_valid next edge; rx_read coincident with byte completion SHALL leave rx_valid=1, rx_data=new byte, no overrun.
REQ-026 con_read SHALL clear tx_done, rx_overrun, frame_error; a set event in the same cycle SHALL win.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 reset=0 SHALL immediately force uart_tx=1, rx_data=0x00, uart_con=5'b00000, both FSMs IDLE, all counters 0, regardless of clk.
REQ-029 Reset asserted mid-frame SHALL abort both directions; after release the receiver waits for a fresh falling edge.
REQ-030 tx_start, rx_read, con_read asserted while reset=0 SHALL have no effect.

Verification (CLK_FREQ=16, BAUD=1, DIV=16)
REQ-031 Release reset -> uart_tx=1, rx_data=0x00, uart_con=0x00.
REQ-032 tx_start pulse with tx_data=0xA5 at edge T -> uart_tx=0 for edges T+1..T+16, then bits 1,0,1,0,0,1,0,1 each 16 cycles, stop high 16 cycles; tx_busy=0, tx_done=1 at T+161; second tx_start at T+20 ignored.
REQ-033 Drive frame 0x3C on uart_rx -> rx_data=0x3C, uart_con[0]=1; rx_read pulse -> uart_con[0]=0, rx_data stays 0x3C.
REQ-034 Frames 0x11 then 0x22 with no rx_read -> rx_data=0x22, uart_con[3]=1; con_read -> uart_con[3]=0, uart_con[0] still 1.
REQ-035 Frame 0x55 with stop bit 0 -> uart_con[4]=1, rx_valid and rx_data unchanged; 4-cycle low glitch -> no byte, no flags.
REQ-036 reset=0 at bit 3 of a TX frame -> uart_tx=1 without waiting for clk, uart_con=0x00; new tx_start after release transmits a full frame.
